// File: rtl/priority_encoder.sv
// Registered one-hot priority encoder on a valid-qualified word stream.
// Outputs the highest (left) and lowest (right) set bit of each valid word.
//
// Ports:
//   clk_i        - clock, rising edge
//   srst_i       - synchronous reset, active low
//   data_i       - input word, sampled when data_val_i = 1
//   data_val_i   - input qualifier
//   data_left_o  - one-hot of highest set bit, 0 for a zero word
//   data_right_o - one-hot of lowest set bit, 0 for a zero word
//   data_val_o   - data_val_i delayed one cycle
//
// Optional (define PRIORITY_ENCODER_INDEX_EN):
//   data_left_idx_o  - binary index of highest set bit
//   data_right_idx_o - binary index of lowest set bit
//   data_zero_o      - captured word was zero (both indices are 0)
module priority_encoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic             data_val_o
`ifdef PRIORITY_ENCODER_INDEX_EN
  ,
  output logic [$clog2(WIDTH)-1:0] data_left_idx_o,
  output logic [$clog2(WIDTH)-1:0] data_right_idx_o,
  output logic                     data_zero_o
`endif
);

  logic [WIDTH-1:0] left_n;
  logic [WIDTH-1:0] right_n;

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    left_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        left_n    = '0;
        left_n[i] = 1'b1;
      end
    end
  end

  // Descending scan: the last hit is the lowest set bit.
  always_comb begin
    right_n = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) begin
        right_n    = '0;
        right_n[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      data_left_o  <= '0;
      data_right_o <= '0;
      data_val_o   <= 1'b0;
    end else begin
      data_val_o <= data_val_i;
      if (data_val_i) begin
        data_left_o  <= left_n;
        data_right_o <= right_n;
      end
    end
  end

`ifdef PRIORITY_ENCODER_INDEX_EN
  localparam int IW = $clog2(WIDTH);

  logic [IW-1:0] left_idx_n;
  logic [IW-1:0] right_idx_n;

  always_comb begin
    left_idx_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) left_idx_n = IW'(i);
    end
  end

  always_comb begin
    right_idx_n = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) right_idx_n = IW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      data_left_idx_o  <= '0;
      data_right_idx_o <= '0;
      data_zero_o      <= 1'b0;
    end else if (data_val_i) begin
      data_left_idx_o  <= left_idx_n;
      data_right_idx_o <= right_idx_n;
      data_zero_o      <= ~|data_i;
    end
  end
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Testbench for priority_encoder: directed table at WIDTH=8, then a
// random stream on WIDTH=8 and WIDTH=13 instances against a model.
module tb_priority_encoder;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [7:0]  d8;
  logic        v8;
  logic [7:0]  l8, r8;
  logic        vo8;
  logic [12:0] d13;
  logic        v13;
  logic [12:0] l13, r13;
  logic        vo13;

`ifdef PRIORITY_ENCODER_INDEX_EN
  logic [2:0] li8, ri8;
  logic       z8;
  logic [3:0] li13, ri13;
  logic       z13;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  priority_encoder #(.WIDTH(8)) u8 (
    .clk_i(clk_i),
    .srst_i(srst_i),
    .data_i(d8),
    .data_val_i(v8),
    .data_left_o(l8),
    .data_right_o(r8),
    .data_val_o(vo8)
`ifdef PRIORITY_ENCODER_INDEX_EN
    ,
    .data_left_idx_o(li8),
    .data_right_idx_o(ri8),
    .data_zero_o(z8)
`endif
  );

  priority_encoder #(.WIDTH(13)) u13 (
    .clk_i(clk_i),
    .srst_i(srst_i),
    .data_i(d13),
    .data_val_i(v13),
    .data_left_o(l13),
    .data_right_o(r13),
    .data_val_o(vo13)
`ifdef PRIORITY_ENCODER_INDEX_EN
    ,
    .data_left_idx_o(li13),
    .data_right_idx_o(ri13),
    .data_zero_o(z13)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic       val;
    logic [7:0] data;
    logic [7:0] left;
    logic [7:0] right;
    logic       oval;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] msb_oh(input logic [12:0] x);
    logic [12:0] r;
    logic        found;
    r     = '0;
    found = 1'b0;
    for (int i = 12; i >= 0; i--) begin
      if (x[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [12:0] lsb_oh(input logic [12:0] x);
    return x & (~x + 13'd1);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [12:0] e_l8, e_r8, e_l13, e_r13;
  logic        e_v8, e_v13;

  initial begin
    srst_i = 1'b0;
    d8     = '0;
    v8     = 1'b0;
    d13    = '0;
    v13    = 1'b0;

    vt[0]  = '{1'b0, 1'b0, 8'h00,        8'h00, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 8'b01001000,  8'h40, 8'h08, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 8'b11001001,  8'h80, 8'h01, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 8'b00111100,  8'h80, 8'h01, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 8'b00000000,  8'h00, 8'h00, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 8'b00010000,  8'h10, 8'h10, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 8'b11111111,  8'h80, 8'h01, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 8'b00100100,  8'h00, 8'h00, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 8'bxxxxxxxx,  8'h00, 8'h00, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 8'b00000001,  8'h01, 8'h01, 1'b1};
    vt[10] = '{1'b1, 1'b1, 8'b10000000,  8'h80, 8'h80, 1'b1};

    for (int i = 0; i < 11; i++) begin
      srst_i = vt[i].rst_n;
      v8     = vt[i].val;
      d8     = vt[i].data;
      step();
      chk($sformatf("v%0d left", i), 32'(l8), 32'(vt[i].left));
      chk($sformatf("v%0d right", i), 32'(r8), 32'(vt[i].right));
      chk($sformatf("v%0d val", i), 32'(vo8), 32'(vt[i].oval));
    end

    // Several idle cycles after a valid word: data holds, valid stays low.
    v8 = 1'b0;
    d8 = 8'h0f;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle left", 32'(l8), 32'h80);
      chk("idle right", 32'(r8), 32'h80);
      chk("idle val", 32'(vo8), 32'h0);
    end

`ifdef PRIORITY_ENCODER_INDEX_EN
    v8 = 1'b1;
    d8 = 8'b01001000;
    step();
    chk("idx left", 32'(li8), 32'd6);
    chk("idx right", 32'(ri8), 32'd3);
    chk("idx zero", 32'(z8), 32'd0);
    d8 = 8'h00;
    step();
    chk("zero flag", 32'(z8), 32'd1);
    chk("zero lidx", 32'(li8), 32'd0);
    chk("zero ridx", 32'(ri8), 32'd0);
`endif

    // Reset mid-stream to start the random phase from a known state.
    srst_i = 1'b0;
    v8     = 1'b1;
    d8     = 8'hff;
    v13    = 1'b1;
    d13    = 13'h1fff;
    step();
    chk("rst val8", 32'(vo8), 32'h0);
    chk("rst val13", 32'(vo13), 32'h0);
    chk("rst left13", 32'(l13), 32'h0);
    srst_i = 1'b1;
    e_l8   = '0;
    e_r8   = '0;
    e_l13  = '0;
    e_r13  = '0;

    for (int n = 0; n < 1000; n++) begin
      v8  = 1'($urandom_range(0, 1));
      v13 = 1'($urandom_range(0, 1));
      d8  = (($urandom_range(0, 15)) == 0) ? 8'h00 : 8'($urandom);
      d13 = (($urandom_range(0, 15)) == 0) ? 13'h0 : 13'($urandom);
      if (v8) begin
        e_l8 = msb_oh({5'b0, d8});
        e_r8 = lsb_oh({5'b0, d8});
      end
      if (v13) begin
        e_l13 = msb_oh(d13);
        e_r13 = lsb_oh(d13);
      end
      e_v8  = v8;
      e_v13 = v13;
      step();
      chk("rnd8 val", 32'(vo8), 32'(e_v8));
      chk("rnd8 left", 32'(l8), 32'(e_l8[7:0]));
      chk("rnd8 right", 32'(r8), 32'(e_r8[7:0]));
      chk("rnd13 val", 32'(vo13), 32'(e_v13));
      chk("rnd13 left", 32'(l13), 32'(e_l13));
      chk("rnd13 right", 32'(r13), 32'(e_r13));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
